upower_issue_ctrl: RTL
======================

# upower_issue_ctrl

Multicycle fetch/decode/execute/writeback sequencer for the uPower core. It fetches 32-bit instructions from instruction memory and holds each one stable for the instruction parser. It then strobes the ALU, waits for completion and issues the register-file write. It also owns the program counter, redirects on taken branches, and stops on an illegal opcode or a stop request.

## Interface
- `PC_W`, 32, program counter / fetch address width
- `RESET_PC`, 0, PC value after reset
- `WDOG_MAX`, 15, max EXEC cycles before watchdog trip (used only when the macro is defined)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  leave IDLE and begin fetching at current PC
- `stop_req`  in  1  finish current instruction, then return to IDLE
- `imem_req`  out  1  fetch request, held until ack
- `imem_addr`  out  PC_W  fetch address (= PC)
- `imem_ack`  in  1  fetch data valid this cycle
- `imem_data`  in  32  fetched instruction
- `instr`  out  32  latched instruction to the parser, stable from DECODE through WB
- `alu_start`  out  1  one-cycle pulse on EXEC entry
- `alu_done`  in  1  ALU result ready
- `br_taken`  in  1  branch resolved taken (sampled with alu_done)
- `br_target`  in  PC_W  branch target (sampled with alu_done)
- `rf_we`  out  1  register-file write strobe, one cycle in WB
- `busy`  out  1  state ≠ IDLE and ≠ HALT
- `halted`  out  1  in HALT state
- `fault`  out  2  0 none, 1 illegal opcode, 2 watchdog
- `retired`  out  32  retired-instruction counter
- `pc`  out  PC_W  current program counter

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE → FETCH when `start`=1.
- FETCH: `imem_req`=1, `imem_addr`=PC. On `imem_ack`: latch `imem_data` into `instr` and go to DECODE.
- DECODE: opcode = `instr[31:26]`.
  - Opcode 0 → HALT, `fault`=1. PC is not advanced.
  - Otherwise → EXEC.
- EXEC: `alu_start` is pulsed in the first EXEC cycle only, then the block waits for `alu_done`.
  - Branch opcodes (18, 19): next PC = `br_target` if `br_taken`, else PC+4. Then → WB.
  - All other opcodes: next PC = PC+4. Then → WB.
- WB:
  - `rf_we`=1, except for no-writeback opcodes: 18, 19, 36, 37, 38, 44, 62.
  - PC takes the next-PC value and `retired` increments.
  - Next state: IDLE if a stop is pending, else FETCH.
- `stop_req` is latched as pending in any busy state and cleared on entry to IDLE. A stop never aborts FETCH or EXEC.
- HALT is sticky. Only `reset` exits it; `start` is ignored while in HALT.
- PC arithmetic is modulo 2^PC_W, so PC+4 wraps. `retired` wraps modulo 2^32.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `instr`=0, `retired`=0, `fault`=0, stop-pending=0. All strobes are 0, `busy`=0, `halted`=0.
- `imem_ack` in the same cycle `imem_req` rises is accepted, giving a minimum fetch of 1 cycle. Best case per instruction is 4 cycles: FETCH, DECODE, EXEC (with `alu_done` in the first EXEC cycle), WB.
- `alu_done` during the `alu_start` cycle is accepted.
- `alu_done`, `imem_ack`, `br_*` outside their states are ignored.
- `imem_addr` and `instr` are held constant while waiting.
- Asynchronous reset mid-FETCH or mid-EXEC drops `imem_req`/`alu_start` immediately. No `rf_we` or retire occurs.
- `start` and `stop_req` together in IDLE: the block fetches, then executes exactly one instruction, then returns to IDLE.

## Configuration
- `UPOWER_ISSUE_WDOG_EN` defined:
  - A counter starts at 0 on EXEC entry.
  - If it reaches `WDOG_MAX` without `alu_done`, the block goes to HALT with `fault`=2 and suppresses WB and retire.
- Undefined: EXEC waits indefinitely, `fault` never takes value 2, and `WDOG_MAX` is unused.

## Test plan
- Reset, `start`. The instruction at 0 is addi (opcode 14), `imem_ack` and `alu_done` are immediate → `imem_addr`=0, `alu_start` 1 pulse, `rf_we` in cycle 4, PC=4, `retired`=1.
- `imem_ack` delayed 3 cycles → `imem_req`/`imem_addr` held steady. The instruction is latched only on the ack cycle.
- Opcode 18 with `br_taken`=1, `br_target`=0x100 → no `rf_we`, PC=0x100, next `imem_addr`=0x100. Same instruction with `br_taken`=0 → PC=PC+4.
- Stw (opcode 36) → WB with `rf_we`=0, `retired` increments. Instruction word 0 → HALT, `fault`=1, PC unchanged, `start` ignored until reset.
- `stop_req` pulsed during EXEC → instruction completes, state returns to IDLE, `busy`=0, no further `imem_req`.
- With `UPOWER_ISSUE_WDOG_EN`, `WDOG_MAX`=15, `alu_done` never asserted → HALT after 15 EXEC cycles, `fault`=2, `retired` unchanged. Without the macro → still in EXEC after 100 cycles.

Source files
------------

// File: rtl/upower_issue_ctrl.sv
// Multicycle fetch/decode/execute/writeback sequencer: owns PC, instruction latch, ALU/RF strobes.
// Optional EXEC watchdog enabled by defining UPOWER_ISSUE_WDOG_EN (fault=2 on trip).
module upower_issue_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              WDOG_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     instr,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            rf_we,
  output logic            busy,
  output logic            halted,
  output logic [1:0]      fault,
  output logic [31:0]     retired,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] npc, npc_nx;
  logic            exec_first;
  logic            stop_pend;
  logic [5:0]      opcode;
  logic            is_branch;
  logic            no_wb;
  logic            wdog_trip;

  assign opcode    = instr[31:26];
  assign is_branch = (opcode == 6'd18) || (opcode == 6'd19);

  always_comb begin
    no_wb = 1'b0;
    case (opcode)
      6'd18, 6'd19, 6'd36, 6'd37, 6'd38, 6'd44, 6'd62: no_wb = 1'b1;
      default: no_wb = 1'b0;
    endcase
  end

`ifdef UPOWER_ISSUE_WDOG_EN
  localparam int WDW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX + 1) : 1;
  logic [WDW-1:0] wdog_cnt;

  // Count restarts on every EXEC entry; trip in the WDOG_MAX-th EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wdog_cnt <= '0;
    else if (state != EXEC)  wdog_cnt <= '0;
    else                     wdog_cnt <= wdog_cnt + 1'b1;
  end
  assign wdog_trip = (wdog_cnt == WDW'(WDOG_MAX - 1));
`else
  localparam int unused_wdog_max = WDOG_MAX;
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    npc_nx    = npc;
    imem_req  = 1'b0;
    alu_start = 1'b0;
    rf_we     = 1'b0;
    case (state)
      IDLE:   if (start) state_nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nx = DECODE;
      end
      DECODE: state_nx = (opcode == 6'd0) ? HALT : EXEC;
      EXEC: begin
        alu_start = exec_first;
        if (alu_done) begin
          state_nx = WB;
          npc_nx   = (is_branch && br_taken) ? br_target : pc + PC_W'(4);
        end else if (wdog_trip) begin
          state_nx = HALT;
        end
      end
      WB: begin
        rf_we    = ~no_wb;
        state_nx = (stop_pend || stop_req) ? IDLE : FETCH;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      npc        <= RESET_PC;
      instr      <= '0;
      retired    <= '0;
      fault      <= 2'd0;
      stop_pend  <= 1'b0;
      exec_first <= 1'b0;
    end else begin
      state      <= state_nx;
      npc        <= npc_nx;
      exec_first <= (state_nx == EXEC) && (state != EXEC);
      if (state == FETCH && imem_ack) instr <= imem_data;
      if (state == DECODE && opcode == 6'd0) fault <= 2'd1;
      if (state == EXEC && !alu_done && wdog_trip) fault <= 2'd2;
      if (state == WB) begin
        pc      <= npc;
        retired <= retired + 32'd1;
      end
      // A stop seen together with start in IDLE still lets one instruction run.
      if (state == WB && state_nx == IDLE)
        stop_pend <= 1'b0;
      else if (stop_req && (busy || (state == IDLE && start)))
        stop_pend <= 1'b1;
    end
  end

endmodule
